// File: rtl/bram_wr_pkg.sv
`default_nettype none
// ============================================================================
// Module : bram_wr_pkg
// Brief  : Shared widths, FSM state encoding and helpers for the BRAM arbiters.
// Rev    : 1.0  initial release
// ============================================================================
package bram_wr_pkg;

    localparam int BRAM_ADDR_W = 13;
    localparam int BRAM_DATA_W = 32;
    localparam int GRANT_W     = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_ACK   = 2'd2
    } arb_state_t;

    // Index width for an N-entry requester vector; never narrower than 1 bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bram_wr_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module : bram_wr_arbiter_if
// Brief  : Requester-side and BRAM-controller-side signals of the write arbiter.
// Rev    : 1.0  initial release
// ============================================================================
interface bram_wr_arbiter_if
    import bram_wr_pkg::*;
#(
    parameter int N_REQ  = 4,
    parameter int ADDR_W = BRAM_ADDR_W,
    parameter int DATA_W = BRAM_DATA_W
) ();

    logic [N_REQ-1:0]        req_trig;
    logic [N_REQ*ADDR_W-1:0] req_addr;
    logic [N_REQ*DATA_W-1:0] req_data;
    logic [N_REQ-1:0]        req_done;
    logic [ADDR_W-1:0]       wr_addr;
    logic [DATA_W-1:0]       wr_data;
    logic                    wr_trig;
    logic                    wr_done;

    // master: requesters plus downstream controller; slave: the arbiter itself
    modport master (
        output req_trig, req_addr, req_data, wr_done,
        input  req_done, wr_addr, wr_data, wr_trig
    );

    modport slave (
        input  req_trig, req_addr, req_data, wr_done,
        output req_done, wr_addr, wr_data, wr_trig
    );

endinterface
`default_nettype wire

// File: rtl/bram_wr_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module : rr_pick
// Brief  : Combinational round-robin select, searching upward from last+1.
// Rev    : 1.0  initial release
// ============================================================================
module rr_pick
    import bram_wr_pkg::*;
#(
    parameter int N_REQ = 4,
    localparam int IDX_W = idx_w(N_REQ)
) (
    input  wire logic [N_REQ-1:0] i_req,
    input  wire logic [IDX_W-1:0] i_last,
    output logic      [IDX_W-1:0] o_idx,
    output logic                  o_valid
);

    always_comb begin
        o_idx   = '0;
        o_valid = 1'b0;
        for (int i = 1; i <= N_REQ; i++) begin : g_scan
            int               kk;
            logic [IDX_W-1:0] k;
            kk = (int'(i_last) + i) % N_REQ;
            k  = IDX_W'(kk);
            if (!o_valid && i_req[k]) begin
                o_valid = 1'b1;
                o_idx   = k;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/bram_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module : bram_wr_arbiter
// Brief  : Round-robin share of one BRAM write controller among N_REQ writers.
// Rev    : 1.0  initial release
// ============================================================================
module bram_wr_arbiter
    import bram_wr_pkg::*;
#(
    parameter int N_REQ       = 4,
    parameter int ADDR_W      = BRAM_ADDR_W,
    parameter int DATA_W      = BRAM_DATA_W,
    parameter int TIMEOUT_CYC = 0
) (
    input  wire logic               i_clk,
    input  wire logic               i_rstn,
    bram_wr_arbiter_if.slave        bus,
    output logic [GRANT_W-1:0]      o_grant_idx,
    output logic                    o_busy,
    output logic                    o_timeout_err
);

    localparam int          IDX_W   = idx_w(N_REQ);
    localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CYC - 1);

    logic [IDX_W-1:0]  w_pick_idx;
    logic              w_pick_valid;

    arb_state_t        r_state,    w_state_nxt;
    logic              r_trig,     w_trig_nxt;
    logic [N_REQ-1:0]  r_done_pre, w_done_pre_nxt;
    logic [IDX_W-1:0]  r_grant,    w_grant_nxt;
    logic [IDX_W-1:0]  r_last,     w_last_nxt;
    logic [ADDR_W-1:0] r_addr,     w_addr_nxt;
    logic [DATA_W-1:0] r_data,     w_data_nxt;
    logic [31:0]       r_cnt,      w_cnt_nxt;
    logic              r_terr,     w_terr_nxt;

    rr_pick #(.N_REQ(N_REQ)) u_rr_pick (
        .i_req   (bus.req_trig),
        .i_last  (r_last),
        .o_idx   (w_pick_idx),
        .o_valid (w_pick_valid)
    );

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            r_state    <= ST_IDLE;
            r_trig     <= 1'b0;
            r_done_pre <= '0;
            r_grant    <= '0;
            r_last     <= IDX_W'(N_REQ - 1);
            r_addr     <= '0;
            r_data     <= '0;
            r_cnt      <= '0;
            r_terr     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_trig     <= w_trig_nxt;
            r_done_pre <= w_done_pre_nxt;
            r_grant    <= w_grant_nxt;
            r_last     <= w_last_nxt;
            r_addr     <= w_addr_nxt;
            r_data     <= w_data_nxt;
            r_cnt      <= w_cnt_nxt;
            r_terr     <= w_terr_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_trig_nxt     = r_trig;
        w_done_pre_nxt = r_done_pre;
        w_grant_nxt    = r_grant;
        w_last_nxt     = r_last;
        w_addr_nxt     = r_addr;
        w_data_nxt     = r_data;
        w_cnt_nxt      = r_cnt;
        w_terr_nxt     = r_terr;
        case (r_state)
            ST_IDLE: begin
                // A downstream done still high from the last write blocks a new issue.
                if (w_pick_valid && !bus.wr_done) begin
                    w_grant_nxt = w_pick_idx;
                    w_addr_nxt  = bus.req_addr[int'(w_pick_idx)*ADDR_W +: ADDR_W];
                    w_data_nxt  = bus.req_data[int'(w_pick_idx)*DATA_W +: DATA_W];
                    w_trig_nxt  = 1'b1;
                    w_cnt_nxt   = '0;
                    w_state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                w_cnt_nxt = r_cnt + 32'd1;
                if (bus.wr_done) begin
                    w_trig_nxt              = 1'b0;
                    w_done_pre_nxt[r_grant] = 1'b1;
                    w_last_nxt              = r_grant;
                    w_state_nxt             = ST_ACK;
                end else if ((TIMEOUT_CYC != 0) && (r_cnt == TO_LAST)) begin
                    w_trig_nxt              = 1'b0;
                    w_terr_nxt              = 1'b1;
                    w_done_pre_nxt[r_grant] = 1'b1;
                    w_last_nxt              = r_grant;
                    w_state_nxt             = ST_ACK;
                end
            end
            ST_ACK: begin
                if (!bus.req_trig[r_grant] && !bus.wr_done) begin
                    w_done_pre_nxt = '0;
                    w_state_nxt    = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Done is gated by the live trig so it drops in the same cycle as the request.
    assign bus.req_done  = r_done_pre & bus.req_trig;
    assign bus.wr_addr   = r_addr;
    assign bus.wr_data   = r_data;
    assign bus.wr_trig   = r_trig;
    assign o_grant_idx   = GRANT_W'(r_grant);
    assign o_busy        = (r_state != ST_IDLE);
    assign o_timeout_err = r_terr;

endmodule
`default_nettype wire

// File: tb/tb_bram_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module : tb_bram_wr_arbiter
// Brief  : Scoreboard bench: requesters, controller model and grant monitor.
// Rev    : 1.0  initial release
// ============================================================================
module tb_bram_wr_arbiter;
    import bram_wr_pkg::*;

    localparam int N  = 4;
    localparam int AW = 13;
    localparam int DW = 32;
    localparam int TO = 8;

    typedef struct packed {
        logic [2:0]    idx;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } exp_t;

    logic       clk  = 1'b0;
    logic       rstn = 1'b0;
    logic [2:0] gidx;
    logic       busy;
    logic       terr;

    exp_t sb[$];
    int   total      = 0;
    int   bad        = 0;
    int   model_last = N - 1;
    int   fix_lat    = 0;
    bit   hang       = 1'b0;

    always #5 clk = ~clk;

    bram_wr_arbiter_if #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW)) bus ();

    bram_wr_arbiter #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYC(TO)) dut (
        .i_clk         (clk),
        .i_rstn        (rstn),
        .bus           (bus.slave),
        .o_grant_idx   (gidx),
        .o_busy        (busy),
        .o_timeout_err (terr)
    );

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Downstream controller: done after a latency, held until trig drops.
    initial begin
        int cnt = 0;
        int lat = 1;
        bus.wr_done = 1'b0;
        forever begin
            @(negedge clk);
            if (!rstn) begin
                bus.wr_done = 1'b0;
                cnt = 0;
            end else if (bus.wr_trig && !bus.wr_done) begin
                if (cnt == 0) lat = (fix_lat != 0) ? fix_lat : int'($urandom_range(1, 4));
                if (!hang) begin
                    cnt++;
                    if (cnt >= lat) bus.wr_done = 1'b1;
                end
            end else if (!bus.wr_trig) begin
                bus.wr_done = 1'b0;
                cnt = 0;
            end
        end
    end

    // Monitor: pops one expectation per new downstream write, checks invariants.
    initial begin
        logic prev = 1'b0;
        exp_t cur  = '0;
        forever begin
            @(negedge clk);
            #1;
            if (rstn) begin
                total++;
                if ($countones(bus.req_done) > 1 || (bus.req_done & ~bus.req_trig) != '0) begin
                    bad++;
                    $display("FAIL done_onehot: got done=%b trig=%b", bus.req_done, bus.req_trig);
                end
                if (bus.wr_trig && !prev) begin
                    if (sb.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_grant: got idx=%0d expected none", gidx);
                    end else begin
                        cur = sb.pop_front();
                        check("grant_idx", 64'(gidx), 64'(cur.idx));
                        check("wr_addr", 64'(bus.wr_addr), 64'(cur.a));
                        check("wr_data", 64'(bus.wr_data), 64'(cur.d));
                    end
                end else if (bus.wr_trig) begin
                    check("frozen_addr", 64'(bus.wr_addr), 64'(cur.a));
                    check("frozen_data", 64'(bus.wr_data), 64'(cur.d));
                end
            end
            prev = bus.wr_trig;
        end
    end

    task automatic do_req(input int k, input logic [AW-1:0] a, input logic [DW-1:0] d);
        int n = 0;
        bus.req_addr[k*AW +: AW] = a;
        bus.req_data[k*DW +: DW] = d;
        bus.req_trig[k] = 1'b1;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.req_done[k] && n < 300);
        check($sformatf("req_done_%0d", k), 64'(bus.req_done[k]), 64'd1);
        bus.req_trig[k] = 1'b0;
    endtask

    task automatic wait_idle(input string nm);
        int n = 0;
        @(negedge clk);
        while (busy && n < 60) begin
            @(negedge clk);
            n++;
        end
        check(nm, 64'(busy), 64'd0);
    endtask

    // All members of s raise trig together; order is rotation after the last grant.
    task automatic run_round(input logic [N-1:0] s);
        logic [AW-1:0] a[N];
        logic [DW-1:0] d[N];
        int lastk = model_last;
        for (int k = 0; k < N; k++) begin
            a[k] = AW'($urandom);
            d[k] = $urandom;
        end
        for (int i = 1; i <= N; i++) begin
            int k = (model_last + i) % N;
            if (s[k]) begin
                sb.push_back(exp_t'{idx: 3'(k), a: a[k], d: d[k]});
                lastk = k;
            end
        end
        model_last = lastk;
        fork
            begin if (s[0]) do_req(0, a[0], d[0]); end
            begin if (s[1]) do_req(1, a[1], d[1]); end
            begin if (s[2]) do_req(2, a[2], d[2]); end
            begin if (s[3]) do_req(3, a[3], d[3]); end
        join
        wait_idle("round_idle");
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [AW-1:0] fa0[3], fa2[3], ab;
        logic [DW-1:0] fd0[3], fd2[3], db;
        int n, cnt, th;
        bit seen;
        bus.req_trig = '0;
        bus.req_addr = '0;
        bus.req_data = '0;
        repeat (3) @(negedge clk);
        check("rst_wr_trig", 64'(bus.wr_trig), 64'd0);
        check("rst_done", 64'(bus.req_done), 64'd0);
        check("rst_gidx", 64'(gidx), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_terr", 64'(terr), 64'd0);
        check("rst_addr", 64'(bus.wr_addr), 64'd0);
        check("rst_data", 64'(bus.wr_data), 64'd0);
        rstn = 1'b1;
        @(negedge clk);

        // all four at once: 0,1,2,3
        run_round(4'hF);

        // req0 and req2 re-requesting continuously: alternate 0,2
        for (int j = 0; j < 3; j++) begin
            fa0[j] = AW'($urandom); fd0[j] = $urandom;
            fa2[j] = AW'($urandom); fd2[j] = $urandom;
            sb.push_back(exp_t'{idx: 3'd0, a: fa0[j], d: fd0[j]});
            sb.push_back(exp_t'{idx: 3'd2, a: fa2[j], d: fd2[j]});
        end
        model_last = 2;
        fork
            begin for (int j = 0; j < 3; j++) begin do_req(0, fa0[j], fd0[j]); @(negedge clk); end end
            begin for (int j = 0; j < 3; j++) begin do_req(2, fa2[j], fd2[j]); @(negedge clk); end end
        join
        wait_idle("fair_idle");

        // single request, controller done 3 cycles after trig
        fix_lat = 3;
        sb.push_back(exp_t'{idx: 3'd1, a: 13'h0123, d: 32'hDEADBEEF});
        model_last = 1;
        bus.req_addr[1*AW +: AW] = 13'h0123;
        bus.req_data[1*DW +: DW] = 32'hDEADBEEF;
        bus.req_trig[1] = 1'b1;
        @(negedge clk);
        check("single_latency", 64'(bus.wr_trig), 64'd1);
        n = 0;
        while (!bus.req_done[1] && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("single_done", 64'(bus.req_done[1]), 64'd1);
        bus.req_trig[1] = 1'b0;
        #1;
        check("single_done_fall", 64'(bus.req_done[1]), 64'd0);
        wait_idle("single_idle");
        check("idle_hold_addr", 64'(bus.wr_addr), 64'h0123);
        check("idle_hold_data", 64'(bus.wr_data), 64'hDEADBEEF);
        fix_lat = 0;

        for (int r = 0; r < 10; r++) run_round(N'($urandom_range(1, 15)));

        // abort: req3 drops trig one cycle into ISSUE
        fix_lat = 4;
        ab = AW'($urandom);
        db = $urandom;
        sb.push_back(exp_t'{idx: 3'(model_last == 3 ? 3 : 3), a: ab, d: db});
        model_last = 3;
        bus.req_addr[3*AW +: AW] = ab;
        bus.req_data[3*DW +: DW] = db;
        bus.req_trig[3] = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.wr_trig && n < 20);
        check("abort_issue", 64'(bus.wr_trig), 64'd1);
        @(negedge clk);
        bus.req_trig[3] = 1'b0;
        bus.req_addr[3*AW +: AW] = ~ab;
        seen = 1'b0;
        th = 0;
        n = 0;
        while (busy && n < 40) begin
            @(negedge clk);
            n++;
            if (bus.wr_trig) th++;
            if (bus.req_done[3]) seen = 1'b1;
        end
        check("abort_trig_held", 64'(th), 64'd2);
        check("abort_no_done", 64'(seen), 64'd0);
        check("abort_idle", 64'(busy), 64'd0);
        fix_lat = 0;
        run_round(4'b0010);

        // timeout: controller never answers
        hang = 1'b1;
        ab = AW'($urandom);
        db = $urandom;
        sb.push_back(exp_t'{idx: 3'd2, a: ab, d: db});
        model_last = 2;
        bus.req_addr[2*AW +: AW] = ab;
        bus.req_data[2*DW +: DW] = db;
        bus.req_trig[2] = 1'b1;
        n = 0;
        cnt = 0;
        do begin
            @(negedge clk);
            n++;
            if (bus.wr_trig) cnt++;
        end while (!bus.req_done[2] && n < 60);
        check("to_cycles", 64'(cnt), 64'(TO));
        check("to_done", 64'(bus.req_done[2]), 64'd1);
        check("to_err", 64'(terr), 64'd1);
        bus.req_trig[2] = 1'b0;
        hang = 1'b0;
        wait_idle("to_idle");
        run_round(4'b0010);
        check("to_err_sticky", 64'(terr), 64'd1);

        // reset in the middle of ISSUE
        hang = 1'b1;
        ab = AW'($urandom);
        db = $urandom;
        sb.push_back(exp_t'{idx: 3'd1, a: ab, d: db});
        bus.req_addr[1*AW +: AW] = ab;
        bus.req_data[1*DW +: DW] = db;
        bus.req_trig[1] = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.wr_trig && n < 20);
        @(negedge clk);
        rstn = 1'b0;
        @(negedge clk);
        check("mrst_wr_trig", 64'(bus.wr_trig), 64'd0);
        check("mrst_done", 64'(bus.req_done), 64'd0);
        check("mrst_gidx", 64'(gidx), 64'd0);
        check("mrst_busy", 64'(busy), 64'd0);
        check("mrst_terr", 64'(terr), 64'd0);
        check("mrst_addr", 64'(bus.wr_addr), 64'd0);
        check("mrst_data", 64'(bus.wr_data), 64'd0);
        rstn = 1'b1;
        bus.req_trig[1] = 1'b0;
        hang = 1'b0;
        model_last = N - 1;
        @(negedge clk);
        run_round(4'b0101);

        repeat (3) @(negedge clk);
        check("sb_empty", 64'(sb.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
